// File: rtl/aes_pkg.sv
// aes_pkg: shared AES types, constants and GF(2^8) helpers
package aes_pkg;

    localparam logic [7:0] AES_POLY  = 8'h1B;
    localparam int         AES_NCOLS = 4;

    typedef logic [7:0]  byte_t;
    typedef byte_t [3:0] column_t;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} imc_state_t;

    function automatic byte_t xtime(input byte_t b);
        return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
    endfunction

    function automatic byte_t gf_mul(input byte_t a, input byte_t b);
        byte_t p;
        byte_t t;
        p = '0;
        t = a;
        for (int i = 0; i < 8; i++) begin
            p = b[i] ? (p ^ t) : p;
            t = xtime(t);
        end
        return p;
    endfunction

endpackage

// File: rtl/inv_mixcol_column.sv
// inv_mixcol_column: combinational InvMixColumns transform of one 4-byte column
module inv_mixcol_column
    import aes_pkg::*;
(
    input  column_t col_in,
    output column_t col_out
);

    column_t x2, x4, x8, m9, mb, md, me;

    for (genvar r = 0; r < 4; r++) begin : g_row
        assign x2[r] = xtime(col_in[r]);
        assign x4[r] = xtime(x2[r]);
        assign x8[r] = xtime(x4[r]);
        assign m9[r] = x8[r] ^ col_in[r];
        assign mb[r] = x8[r] ^ x2[r] ^ col_in[r];
        assign md[r] = x8[r] ^ x4[r] ^ col_in[r];
        assign me[r] = x8[r] ^ x4[r] ^ x2[r];
        // each output row rotates the 0e/0b/0d/09 coefficient set by one position
        assign col_out[r] = me[r] ^ mb[(r + 1) % 4] ^ md[(r + 2) % 4] ^ m9[(r + 3) % 4];
    end

endmodule

// File: rtl/inv_mixcol.sv
// inv_mixcol: iterative AES InvMixColumns, one column per cycle through a shared engine
module inv_mixcol
    import aes_pkg::*;
#(
    parameter int NCOLS = AES_NCOLS
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         inv_mixcol_enable,
    input  logic [127:0] olddata,
    output logic [127:0] newdata,
    output logic         inv_mixcol_busy,
    output logic         inv_mixcol_finished
);

    localparam int CW = $clog2(NCOLS);

    // [row][column][bit]: flat byte index = column + 4*row, matching the port layout
    typedef logic [3:0][NCOLS-1:0][7:0] state_t;

    imc_state_t    state, state_n;
    logic [CW-1:0] col, col_n;
    state_t        buffer, buffer_n;
    state_t        result, result_n;
    column_t       col_in, col_out;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state  <= IDLE;
            col    <= '0;
            buffer <= '0;
            result <= '0;
        end else begin
            state  <= state_n;
            col    <= col_n;
            buffer <= buffer_n;
            result <= result_n;
        end
    end

    for (genvar r = 0; r < 4; r++) begin : g_mux
        assign col_in[r] = buffer[r][col];
    end

    inv_mixcol_column u_column (
        .col_in  (col_in),
        .col_out (col_out)
    );

    always_comb begin
        state_n  = state;
        col_n    = col;
        buffer_n = buffer;
        result_n = result;
        case (state)
            IDLE: begin
                if (inv_mixcol_enable) begin
                    buffer_n = olddata;
                    col_n    = '0;
                    state_n  = BUSY;
                end
            end
            BUSY: begin
                for (int r = 0; r < 4; r++) result_n[r[1:0]][col] = col_out[r[1:0]];
                col_n   = (col == CW'(NCOLS - 1)) ? '0 : col + 1'b1;
                state_n = (col == CW'(NCOLS - 1)) ? DONE : BUSY;
            end
            default: state_n = IDLE;
        endcase
    end

    assign newdata             = result;
    assign inv_mixcol_busy     = (state != IDLE);
    assign inv_mixcol_finished = (state == DONE);

endmodule

// File: tb/tb_inv_mixcol.sv
// tb_inv_mixcol: randomized self-checking bench with a cycle-level behavioural model of inv_mixcol
module tb_inv_mixcol;

    logic         clk = 0;
    logic         n_rst = 1;
    logic         enable = 0;
    logic [127:0] olddata = '0;
    logic [127:0] newdata;
    logic         busy, finished;

    int errs = 0;
    int checks = 0;
    int fin_cnt = 0;
    bit go = 0;

    int           m_cnt = 0;
    logic [127:0] m_nd = '0;
    logic [127:0] m_exp = '0;

    always #5 clk = ~clk;

    inv_mixcol dut (
        .clk                 (clk),
        .n_rst               (n_rst),
        .inv_mixcol_enable   (enable),
        .olddata             (olddata),
        .newdata             (newdata),
        .inv_mixcol_busy     (busy),
        .inv_mixcol_finished (finished)
    );

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p ^= 16'(a) << i;
        for (int i = 15; i >= 8; i--) if (p[i]) p ^= 16'h11B << (i - 8);
        return p[7:0];
    endfunction

    function automatic logic [127:0] mix(input logic [127:0] s, input bit inverse);
        logic [7:0]   c [4];
        logic [127:0] o;
        logic [7:0]   acc;
        if (inverse) begin
            c[0] = 8'h0e; c[1] = 8'h0b; c[2] = 8'h0d; c[3] = 8'h09;
        end else begin
            c[0] = 8'h02; c[1] = 8'h03; c[2] = 8'h01; c[3] = 8'h01;
        end
        o = '0;
        for (int j = 0; j < 4; j++)
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int k = 0; k < 4; k++) acc ^= gm(c[(k - r + 4) % 4], s[8*(j+4*k) +: 8]);
                o[8*(j+4*r) +: 8] = acc;
            end
        return o;
    endfunction

    function automatic logic [127:0] put(input logic [127:0] s, input int j, input logic [31:0] c);
        logic [127:0] o;
        o = s;
        for (int k = 0; k < 4; k++) o[8*(j+4*k) +: 8] = c[31-8*k -: 8];
        return o;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // model: a start accepted when idle makes busy last 5 cycles, columns land one per cycle
    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            m_cnt = 0;
            m_nd  = '0;
        end else if (m_cnt == 0) begin
            if (enable) begin
                m_cnt = 5;
                m_exp = mix(olddata, 1);
            end
        end else begin
            if (m_cnt >= 2)
                for (int k = 0; k < 4; k++)
                    m_nd[8*((5-m_cnt)+4*k) +: 8] = m_exp[8*((5-m_cnt)+4*k) +: 8];
            m_cnt--;
        end
    end

    always @(negedge clk) begin
        if (go) begin
            chk("busy", 128'(busy), 128'(m_cnt != 0));
            chk("finished", 128'(finished), 128'(m_cnt == 1));
            chk("newdata", newdata, m_nd);
            if (finished) fin_cnt++;
        end
    end

    task automatic run(input logic [127:0] d, input bit scramble, output logic [127:0] res);
        int bcnt;
        bcnt = 0;
        @(negedge clk);
        olddata = d;
        enable  = 1;
        @(negedge clk);
        enable = 0;
        for (int n = 0; n < 20 && !finished; n++) begin
            if (busy) bcnt++;
            if (scramble) olddata = rnd128();
            @(negedge clk);
        end
        if (!finished) chk("timeout", 128'(finished), 128'(1));
        chk("busy_cycles", 128'(bcnt + int'(busy)), 128'(5));
        res = newdata;
        @(negedge clk);
        chk("finished_width", 128'(finished), 128'(0));
    endtask

    logic [127:0] v, e, res, a, b;
    int f0;

    initial begin
        #1 n_rst = 0;
        repeat (2) @(negedge clk);
        chk("rst_newdata", newdata, '0);
        chk("rst_busy", 128'(busy), '0);
        chk("rst_finished", 128'(finished), '0);
        go = 1;
        @(negedge clk);
        n_rst = 1;

        v = put('0, 0, 32'h8e4da1bc);
        e = put('0, 0, 32'hdb135345);
        chk("model_fips", mix(v, 1), e);
        run(v, 0, res);
        chk("fips_col0", res, e);

        v = put(put(put(put('0, 0, 32'h8e4da1bc), 1, 32'h9fdc589d), 2, 32'h01010101), 3, 32'hd5d5d7d6);
        e = put(put(put(put('0, 0, 32'hdb135345), 1, 32'hf20a225c), 2, 32'h01010101), 3, 32'hd4d4d4d5);
        chk("model_full", mix(v, 1), e);
        chk("model_fwd", mix(e, 0), v);
        run(v, 0, res);
        chk("full_state", res, e);

        v = put(put('0, 3, 32'h4d7ebdf8), 1, 32'hc6c6c6c6);
        e = put(put('0, 3, 32'h2d26314c), 1, 32'hc6c6c6c6);
        chk("model_col3", mix(v, 1), e);
        run(v, 1, res);
        chk("scrambled_input", res, e);

        a = rnd128();
        b = rnd128();
        f0 = fin_cnt;
        @(negedge clk);
        enable = 1;
        for (int i = 0; i < 24; i++) begin
            olddata = i[0] ? b : a;
            @(negedge clk);
        end
        enable = 0;
        chk("b2b_pulses", 128'(fin_cnt - f0), 128'(4));

        @(negedge clk);
        olddata = rnd128();
        enable  = 1;
        @(negedge clk);
        enable = 0;
        @(negedge clk);
        #2 n_rst = 0;
        #1;
        chk("midrst_newdata", newdata, '0);
        chk("midrst_busy", 128'(busy), '0);
        chk("midrst_finished", 128'(finished), '0);
        f0 = fin_cnt;
        @(negedge clk);
        #2 n_rst = 1;
        repeat (8) @(negedge clk);
        chk("midrst_no_pulse", 128'(fin_cnt - f0), '0);
        v = rnd128();
        run(v, 0, res);
        chk("after_reset", res, mix(v, 1));

        for (int i = 0; i < 1000; i++) begin
            v = rnd128();
            run(mix(v, 0), $urandom_range(0, 1) == 1, res);
            chk("roundtrip", res, v);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/inv_mixcol.md
Name: inv_mixcol

Overview:
AES InvMixColumns stage for the decryption datapath. It takes one 128-bit state and produces the inverse column mix. The block is iterative: it processes one 4-byte column per clock over four cycles, reusing a single GF(2^8) column engine, and reports completion with a one-cycle finished pulse. It sits between the inverse-ShiftRows/inverse-SubBytes stages and AddRoundKey in the decryption round controller.

Parameters:
NCOLS, 4, number of state columns processed (fixed by AES; not intended to be overridden)

Ports:
clk  input  1  system clock, rising-edge
n_rst  input  1  asynchronous active-low reset
inv_mixcol_enable  input  1  start request, sampled only in IDLE
olddata  input  128  input state; byte k = olddata[8k+7:8k]
newdata  output  128  registered result state, same byte mapping
inv_mixcol_busy  output  1  high while in BUSY or DONE
inv_mixcol_finished  output  1  one-cycle pulse: newdata is complete

Behaviour:
- Clock and reset: one clock, clk. Reset n_rst is asynchronous, active-low. While n_rst=0: state=IDLE, column counter=0, input buffer=0, newdata=0, busy=0, finished=0.
- State layout: column j (0..3) = bytes j, j+4, j+8, j+12, as rows r0..r3.
- Per-column transform, in GF(2^8) with reduction polynomial x^8+x^4+x^3+x+1 (0x11B):
  - r0' = 0e·r0 ^ 0b·r1 ^ 0d·r2 ^ 09·r3
  - r1' = 09·r0 ^ 0e·r1 ^ 0b·r2 ^ 0d·r3
  - r2' = 0d·r0 ^ 09·r1 ^ 0e·r2 ^ 0b·r3
  - r3' = 0b·r0 ^ 0d·r1 ^ 09·r2 ^ 0e·r3
  - Multiplies are built from xtime chains (x2, x4, x8) and XOR. Integer multiplication is not allowed; all intermediates are 8 bits.
- FSM states:
  - IDLE:
    - enable=1 at edge E0 → latch olddata into the buffer, col=0, go to BUSY.
    - enable=0 → stay in IDLE; newdata holds its last value.
  - BUSY:
    - At each edge E1..E4, write the column-col result into the newdata bytes of column col, then col++.
    - At E4 (col==3) → go to DONE and clear col to 0.
  - DONE:
    - inv_mixcol_finished=1 for exactly this one cycle.
    - Next edge → IDLE.
- Latency: enable sampled at E0 → finished high in the cycle after E4. Result valid from then until the next accepted start.
- Throughput: one state per 6 cycles.
- Boundary conditions:
  - enable held high continuously: a new start is accepted in each IDLE visit, giving back-to-back operation.
  - enable asserted during BUSY or DONE: ignored; no queuing.
  - olddata changes after E0: no effect, because the buffer is used exclusively.
  - newdata during BUSY: updated column by column. Consumers use it only when finished=1.
  - Reset asserted mid-operation: immediate return to the reset values; no finished pulse.
  - busy = (state != IDLE).

Decomposition:
- Shared package aes_pkg:
  - AES_POLY = 8'h1B
  - AES_NCOLS = 4
  - byte_t (8-bit) and column_t (4×byte_t) typedefs
  - FSM enum imc_state_t {IDLE, BUSY, DONE}
  - functions xtime() and gf_mul() (generic GF(2^8) multiply)
- Sub-module inv_mixcol_column: purely combinational, 32-bit column in → 32-bit column out. It is instantiated once and shared across cycles via a column-select mux.

Test Plan:
1. FIPS-197 vector: column 0 = bytes(0,4,8,12) = 8e,4d,a1,bc; other columns all 00; pulse enable → after 5 edges finished=1; column 0 = db,13,53,45; all other bytes 00.
2. Full state:
   - Input columns 0..3 = (8e,4d,a1,bc), (9f,dc,58,9d), (01,01,01,01), (d5,d5,d7,d6).
   - Required output columns: (db,13,53,45), (f2,0a,22,5c), (01,01,01,01), (d4,d4,d4,d5).
   - finished high for exactly 1 cycle; busy high for exactly 5 cycles.
3. Column (4d,7e,bd,f8) in column 3, plus column (c6,c6,c6,c6) in column 1 → (2d,26,31,4c) and (c6,c6,c6,c6); change olddata during BUSY → output unchanged.
4. Hold enable high for 20 cycles with alternating inputs → a finished pulse every 6 cycles; each result matches the GF reference model; enable during BUSY/DONE is ignored.
5. Drive n_rst low at the 2nd BUSY edge → newdata=0, busy=0, finished=0 immediately; no finished pulse; the next start completes correctly.
6. Round-trip: 1000 random states through the team's GF forward-MixColumns model, then through inv_mixcol → output equals the original state bit-exactly.
